// File: rtl/sram_bus_adapter.sv
// ============================================================================
// Module   : sram_bus_adapter
// Purpose  : Bridges a req/gnt/rvalid host data bus onto a single-port SRAM
//            with registered read data. Optional wait states before grant;
//            one response cycle follows every grant.
// Options  : define SRAM_ADAPTER_ERR_EN to range-check host addresses and
//            return an error response (no SRAM access) when out of range.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bus_adapter #(
  parameter int          Width      = 32,
  parameter int          Depth      = 1 << 15,
  parameter logic [31:0] BaseAddr   = 32'h8000_0000,
  parameter int          WaitCycles = 0,
  localparam int         Aw         = $clog2(Depth),
  localparam int         WidthBytes = Width / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [WidthBytes-1:0] data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [Width-1:0]      data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [Width-1:0]      data_rdata_o,
  output logic                  data_err_o,
  output logic                  sram_req_o,
  output logic                  sram_write_o,
  output logic [Aw-1:0]         sram_addr_o,
  output logic [Width-1:0]      sram_wdata_o,
  output logic [Width-1:0]      sram_wmask_o,
  input  logic [Width-1:0]      sram_rdata_i
);

  localparam int              OffW   = $clog2(WidthBytes);
  localparam int              CntW   = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WaitCycles);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StResp = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            we_q, we_d;
  logic [31:0]     offset;
  logic [Width-1:0] be_mask;
  logic            gnt;
  logic            sram_hit;

  // Byte offset from the SRAM base; wraps naturally for addresses below base.
  assign offset = data_addr_i - BaseAddr;

  // Grant once the request has waited the configured number of cycles;
  // reset masks it so nothing reaches the SRAM while rst_i is high.
  assign gnt = data_req_i & ~rst_i & (wait_cnt_q == CntMax);

`ifdef SRAM_ADAPTER_ERR_EN
  logic err_q, err_d;
  logic in_range;

  // A single unsigned compare covers both ends: addresses below base wrap
  // to huge offsets.
  assign in_range = (64'(offset) < (64'(Depth) * 64'(WidthBytes)));
  assign sram_hit = gnt & in_range;
`else
  assign sram_hit = gnt;
`endif

  // Byte enables expanded into a per-bit write mask.
  for (genvar k = 0; k < WidthBytes; k++) begin : g_mask
    assign be_mask[8*k +: 8] = {8{data_be_i[k]}};
  end

  // Host handshake and SRAM command for the grant cycle.
  always_comb begin
    data_gnt_o   = gnt;
    sram_req_o   = sram_hit;
    sram_write_o = sram_hit & data_we_i;
    sram_addr_o  = Aw'(offset >> OffW);
    sram_wdata_o = data_wdata_i;
    sram_wmask_o = (sram_hit & data_we_i) ? be_mask : '0;
  end

  // Next-state: wait counter, response flag and the captured transaction type.
  always_comb begin
    wait_cnt_d = '0;
    state_d    = StIdle;
    we_d       = we_q;
    if (data_req_i && !gnt && (wait_cnt_q != CntMax)) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end else if (data_req_i && !gnt) begin
      wait_cnt_d = wait_cnt_q;
    end
    if (gnt) begin
      state_d = StResp;
      we_d    = data_we_i;
    end
  end

`ifdef SRAM_ADAPTER_ERR_EN
  // Error flag for the pending response.
  always_comb begin
    err_d = err_q;
    if (gnt) begin
      err_d = ~in_range;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
    end
  end

  // Response outputs: data only for successful reads, zero otherwise.
  always_comb begin
    data_rvalid_o = (state_q == StResp);
    data_rdata_o  = '0;
    data_err_o    = 1'b0;
`ifdef SRAM_ADAPTER_ERR_EN
    data_err_o = (state_q == StResp) & err_q;
    if ((state_q == StResp) && !we_q && !err_q) begin
      data_rdata_o = sram_rdata_i;
    end
`else
    if ((state_q == StResp) && !we_q) begin
      data_rdata_o = sram_rdata_i;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_adapter.sv
`default_nettype none

module tb_sram_bus_adapter;

  localparam int          DEPTH = 1 << 15;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    int unsigned tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req3, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic [31:0] sram_rdata;
  logic [31:0] rd3 = 32'h1234_5678;

  logic        gnt, rvalid, err, sreq, swrite;
  logic [31:0] rdata, swdata, swmask;
  logic [14:0] saddr;
  logic        gnt3, rvalid3, err3, sreq3, swrite3;
  logic [31:0] rdata3, swdata3, swmask3;
  logic [14:0] saddr3;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] sram_mem [int unsigned];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_bus_adapter #(.Width(32), .Depth(DEPTH), .BaseAddr(BASE), .WaitCycles(0)) dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .data_err_o(err), .sram_req_o(sreq), .sram_write_o(swrite),
    .sram_addr_o(saddr), .sram_wdata_o(swdata), .sram_wmask_o(swmask),
    .sram_rdata_i(sram_rdata)
  );

  sram_bus_adapter #(.Width(32), .Depth(DEPTH), .BaseAddr(BASE), .WaitCycles(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req3), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
    .data_rdata_o(rdata3), .data_err_o(err3), .sram_req_o(sreq3), .sram_write_o(swrite3),
    .sram_addr_o(saddr3), .sram_wdata_o(swdata3), .sram_wmask_o(swmask3),
    .sram_rdata_i(rd3)
  );

  // SRAM behavioural model: registered read data, bit-masked writes.
  always @(posedge clk) begin
    if (sreq) begin
      if (swrite) begin
        sram_mem[32'(saddr)] = ((sram_mem.exists(32'(saddr)) ? sram_mem[32'(saddr)] : 32'h0) & ~swmask)
                               | (swdata & swmask);
      end else begin
        sram_rdata <= sram_mem.exists(32'(saddr)) ? sram_mem[32'(saddr)] : 32'h0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = b[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // One host transaction; expected SRAM command checked now, response queued.
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    int unsigned off, word;
    logic        inr;
    exp_t        e;
    logic [31:0] old;
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1;
    off  = a - BASE;
    word = (off / 4) % DEPTH;
    inr  = 1'b1;
`ifdef SRAM_ADAPTER_ERR_EN
    inr = (off < DEPTH * 4);
`endif
    chk("gnt", gnt, 1);
    chk("sram_req", sreq, inr);
    if (inr) begin
      chk("sram_addr", saddr, word);
      chk("sram_write", swrite, w);
      chk("sram_wmask", swmask, w ? mask_of(b) : 32'h0);
      if (w) chk("sram_wdata", swdata, d);
    end
    old     = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
    e.tag   = cyc + 1;
    e.err   = !inr;
    e.rdata = (w || !inr) ? 32'h0 : old;
    exp_q.push_back(e);
    if (w && inr) ref_mem[word] = (old & ~mask_of(b)) | (d & mask_of(b));
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    #1;
    chk("idle_gnt", gnt, 0);
    chk("idle_sram_req", sreq, 0);
  endtask

  // Response monitor: pops the scoreboard whenever a response is presented.
  always @(posedge clk) begin
    #1;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'(rvalid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_cycle", cyc, mon_e.tag);
        chk("rdata", rdata, mon_e.rdata);
        chk("err", err, mon_e.err);
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
        chk("missing_rvalid", 32'(rvalid), 1);
        mon_e = exp_q.pop_front();
      end
      chk("idle_rdata", rdata, 0);
      chk("idle_err", err, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b1; req3 = 1'b1; we = 1'b1; be = 4'hF;
    addr = BASE; wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt3", gnt3, 0);
    chk("rst_sram_req", sreq, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    req = 1'b0; req3 = 1'b0;
    rst = 1'b0;

    // Directed write then read-back of the same word.
    issue(1'b1, 4'b0011, 32'h8000_0010, 32'hDEAD_BEEF);
    chk("dir_sram_addr", saddr, 4);
    chk("dir_wmask", swmask, 32'h0000_FFFF);
    issue(1'b0, 4'hF, 32'h8000_0010, 32'h0);
    idle();

    // Four back-to-back reads.
    for (int i = 0; i < 4; i++) issue(1'b0, 4'hF, BASE + 32'(4 * i), 32'h0);
    idle();

    // Boundary addresses: below base and one window above.
    issue(1'b0, 4'hF, 32'h7FFF_FFFC, 32'h0);
    issue(1'b0, 4'hF, 32'h8002_0000, 32'h0);
    issue(1'b1, 4'h0, BASE + 32'h20, 32'hCAFE_F00D);
    idle();

    // Randomized traffic, mostly within a small window so reads hit writes.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        logic [31:0] a;
        if ($urandom_range(0, 9) < 8) a = BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
        else a = $urandom;
        issue(1'($urandom), 4'($urandom), a, $urandom);
      end
    end
    idle();
    idle();

    // Reset right after a grant: the response must be discarded.
    issue(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    @(posedge clk);
    rst = 1'b1;
    exp_q.delete();
    #2;
    chk("rstmid_rvalid", rvalid, 0);
    chk("rstmid_rdata", rdata, 0);
    @(negedge clk);
    #1;
    chk("rstmid_gnt", gnt, 0);
    chk("rstmid_sram_req", sreq, 0);
    chk("rstmid_rvalid2", rvalid, 0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 4'b0011, 32'h8000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 4'hF, 32'h8000_0010, 32'h0);
    idle();
    idle();

    // Wait-state instance: grant on the 4th requesting cycle.
    @(negedge clk);
    req3 = 1'b1; we = 1'b0; be = 4'hF; addr = BASE + 32'h8; wdata = 32'h5555_AAAA;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("ws_gnt", gnt3, (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) begin
        chk("ws_sram_req", sreq3, 1);
        chk("ws_sram_write", swrite3, 0);
        chk("ws_sram_addr", saddr3, 2);
        chk("ws_wmask", swmask3, 0);
        chk("ws_wdata", swdata3, 32'h5555_AAAA);
      end
      @(negedge clk);
    end
    req3 = 1'b0;
    #1;
    chk("ws_rvalid", rvalid3, 1);
    chk("ws_rdata", rdata3, 32'h1234_5678);
    chk("ws_err", err3, 0);
    @(negedge clk);
    #1;
    chk("ws_rvalid_once", rvalid3, 0);

    // Drop the request after two cycles: the count must restart.
    @(negedge clk);
    req3 = 1'b1;
    #1 chk("ws_restart_gnt_a", gnt3, 0);
    @(negedge clk);
    #1 chk("ws_restart_gnt_b", gnt3, 0);
    @(negedge clk);
    req3 = 1'b0;
    #1 chk("ws_dropped_gnt", gnt3, 0);
    @(negedge clk);
    req3 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("ws_restart_gnt", gnt3, (k == 4) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    req3 = 1'b0;
    #1;
    chk("ws_restart_rvalid", rvalid3, 1);

    repeat (3) idle();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
